mult_error_accumulator: RTL
===========================

# mult_error_accumulator

Self-checking result stage that sits directly downstream of the combinational `multiplier` under evaluation. It consumes each applied operand pair and the product the multiplier returned, computes the exact product internally, and accumulates the error metrics the exploration loop scores candidates on: mismatch count, sum of absolute error and maximum absolute error. It does this over a fixed window of samples. Results are read from registered outputs once `done` is asserted.

## Interface
- `WIDTH`, default 2: operand width; product width is 2*WIDTH.
- `N_SAMPLES`, default 20: samples accepted per run; must be ≥1.
- `CNT_W`, default 16: width of the sample and mismatch counters.
- `SUM_W`, default 24: width of the absolute-error sum; must be ≥ 2*WIDTH.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `in_valid`  in  1  `a`/`b`/`p` carry a sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `a`  in  WIDTH  operand A applied to the multiplier.
- `b`  in  WIDTH  operand B applied to the multiplier.
- `p`  in  2*WIDTH  product returned by the multiplier.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  results final; held until the next accepted `start`.
- `sample_cnt`  out  CNT_W  samples accepted this run.
- `mismatch_cnt`  out  CNT_W  samples with `p` ≠ `a*b`.
- `sum_abs_err`  out  SUM_W  Σ|a*b − p|, saturating.
- `max_abs_err`  out  2*WIDTH  max |a*b − p| this run.

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE.
  - IDLE or DONE with `start`=1: clear all counters and accumulators, clear `done`, go to RUN.
  - RUN: `in_ready` = 1 while `sample_cnt` < N_SAMPLES.
  - RUN → DRAIN on the edge that accepts sample number N_SAMPLES.
  - DRAIN → DONE after one cycle, once the pipeline is empty.
- Accept = `in_valid` & `in_ready`. `in_ready` is 0 in IDLE, DRAIN and DONE. `in_valid` without `in_ready` is ignored; no data is held.
- Stage 1 registers the following on the accept edge, together with a stage-valid bit:
  - exact = a*b, full 2*WIDTH bits, unsigned.
  - err = |exact − p|, computed as the larger minus the smaller, 2*WIDTH bits.
  - mis = (err ≠ 0).
- Stage 2, when the stage-valid bit is set:
  - `mismatch_cnt` += mis.
  - `sum_abs_err` += err, zero-extended; saturates at all-ones.
  - `max_abs_err` = max(`max_abs_err`, err).
- `sample_cnt` increments on the accept edge. Counters saturate at all-ones and never wrap.
- `start` is ignored in RUN and DRAIN.
- `start` in DONE restarts the run; the previous results are lost on that edge.

## Timing
- Reset values, asserted asynchronously:
  - state IDLE, `in_ready`=0, `busy`=0, `done`=0.
  - all counters and accumulators 0, stage-valid 0.
- `start` at edge t: RUN from t, so `in_ready`=1 in the cycle after edge t. The first accept is possible at edge t+1.
- Latency: a sample accepted at edge k is reflected in the accumulators after edge k+1.
- Last sample accepted at edge L:
  - state is DRAIN after edge L.
  - accumulators are final and state is DONE after edge L+1.
  - `done`=1 and `busy`=0 from that cycle onward.
- Back-to-back accepts run one per cycle with no bubbles.
- `rst_n` deasserted mid-run: everything returns to reset values immediately, and the partial run is discarded.
- Deassertion of `rst_n` must meet recovery timing to `clk`; the integrator synchronizes it externally.
- `done` and the result outputs are registered, with no combinational path from inputs.

## Test plan
- **Reset state:** assert `rst_n`=0 mid-RUN → all outputs 0 and `in_ready`=0 in the same cycle. After release, the block stays in IDLE until `start`.
- **Exact multiplier:** WIDTH=2, N_SAMPLES=20. Feed the 20 pairs (1,3),(3,2),(1,2),(1,3),(2,2),(1,1),(2,2),(2,1),(1,2),(3,2),(1,3),(2,3),(3,2),(1,2),(3,3),(2,1),(3,3),(1,3),(1,2),(2,3), each with the correct `p`, one per cycle. Required: `done` 2 cycles after the last accept; `sample_cnt`=20, `mismatch_cnt`=0, `sum_abs_err`=0, `max_abs_err`=0.
- **Approximate product:** same stream, but (3,3) returns p=5 on both occurrences and (2,3) returns p=7 once. Required: `mismatch_cnt`=3, `sum_abs_err`=4+4+1=9, `max_abs_err`=4.
- **Handshake:** toggle `in_valid` randomly. Required: only cycles with `in_valid`=1 are counted; `in_ready` drops after the 20th accept; extra `in_valid` pulses in DRAIN or DONE leave all outputs unchanged.
- **Start handling:**
  - `start` pulsed during RUN → ignored, and the run completes normally.
  - `start` pulsed in DONE → accumulators clear to 0 and `done` drops the next cycle, and a new run proceeds.
- **Saturation:** SUM_W=4, every sample with err=9 → `sum_abs_err` sticks at 15 and does not wrap.

Source files
------------

// File: rtl/mult_error_accumulator.sv
// mult_error_accumulator
// Scores a combinational multiplier under evaluation. Each accepted sample
// (a, b, p) is compared against the exact product a*b. Over a window of
// N_SAMPLES samples the block accumulates the mismatch count, the sum of
// absolute errors (saturating) and the maximum absolute error. The block
// raises `done` once the window is complete and the two-stage pipeline is empty.
//
// Handshake: a sample is accepted on a rising clk edge when in_valid and
// in_ready are both 1. in_ready depends only on registered state, never on
// in_valid. in_valid while in_ready is 0 is ignored, and no data is held.
module mult_error_accumulator #(
    parameter int WIDTH     = 2,
    parameter int N_SAMPLES = 20,
    parameter int CNT_W     = 16,
    parameter int SUM_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [SUM_W-1:0]     sum_abs_err,
    output logic [2*WIDTH-1:0]   max_abs_err
);

    localparam int PW = 2 * WIDTH;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] N_LIM   = CNT_W'(N_SAMPLES);
    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic          accept;
    logic          last_accept;
    logic          start_clear;

    logic [PW-1:0] exact;
    logic [PW-1:0] err;

    logic          s1_valid;
    logic [PW-1:0] s1_err;
    logic          s1_mis;

    logic [SUM_W:0] err_ext;
    logic [SUM_W:0] sum_ext;

    // Handshake and control decode from registered state only
    assign in_ready    = (state == RUN) && (sample_cnt < N_LIM);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (sample_cnt == (N_LIM - CNT_ONE));
    assign start_clear = start && ((state == IDLE) || (state == DONE));
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);

    // Exact product and absolute error: larger operand minus the smaller one
    assign exact = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign err   = (exact >= p) ? (exact - p) : (p - exact);

    // Saturating add of the stage-1 error into the running sum
    assign err_ext = {{(SUM_W + 1 - PW){1'b0}}, s1_err};
    assign sum_ext = {1'b0, sum_abs_err} + err_ext;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only counts in IDLE/DONE, DRAIN lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_accept) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: capture the error of the accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
            s1_mis   <= 1'b0;
        end else if (start_clear) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
            s1_mis   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err <= err;
                s1_mis <= (err != '0);
            end
        end
    end

    // Stage 2 and sample counter: saturating accumulation of the metrics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
        end else if (start_clear) begin
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
        end else begin
            if (accept && (sample_cnt != CNT_MAX)) begin
                sample_cnt <= sample_cnt + CNT_ONE;
            end
            if (s1_valid) begin
                if (s1_mis && (mismatch_cnt != CNT_MAX)) begin
                    mismatch_cnt <= mismatch_cnt + CNT_ONE;
                end
                if (sum_ext[SUM_W]) begin
                    sum_abs_err <= SUM_MAX;
                end else begin
                    sum_abs_err <= sum_ext[SUM_W-1:0];
                end
                if (s1_err > max_abs_err) begin
                    max_abs_err <= s1_err;
                end
            end
        end
    end

endmodule
